// File: rtl/tsc_isa_pkg.sv
// TSC ISA encodings and ALU FuncCode values shared by the issue stage and the EX-stage ALU.
// Also holds the decoded control bundle type carried through the ID/EX register.
package tsc_isa_pkg;
  localparam int ISA_W   = 16;
  localparam int ISA_RAW = 2;
  localparam logic [ISA_RAW-1:0] ISA_LINK_REG = 2'd2;

  localparam logic [3:0] OP_BNE = 4'd0, OP_BEQ = 4'd1, OP_BGZ = 4'd2, OP_BLZ = 4'd3,
                         OP_ADI = 4'd4, OP_ORI = 4'd5, OP_LHI = 4'd6, OP_LWD = 4'd7,
                         OP_SWD = 4'd8, OP_JMP = 4'd9, OP_JAL = 4'd10, OP_RTYPE = 4'd15;

  localparam logic [5:0] FN_ADD = 6'd0, FN_SUB = 6'd1, FN_AND = 6'd2, FN_ORR = 6'd3,
                         FN_NOT = 6'd4, FN_TCP = 6'd5, FN_SHL = 6'd6, FN_SHR = 6'd7,
                         FN_JPR = 6'd25, FN_JRL = 6'd26, FN_WWD = 6'd28, FN_HLT = 6'd29;

  localparam logic [3:0] ALU_ADD = 4'd0,  ALU_SUB = 4'd1,  ALU_IDA = 4'd2,  ALU_NOT = 4'd3,
                         ALU_AND = 4'd4,  ALU_OR  = 4'd5,  ALU_NE  = 4'd6,  ALU_EQ  = 4'd7,
                         ALU_GTZ = 4'd8,  ALU_LTZ = 4'd9,  ALU_IDB = 4'd10, ALU_SHL = 4'd12,
                         ALU_SRA = 4'd13, ALU_NEG = 4'd14, ALU_ZERO = 4'd15;

  typedef enum logic [1:0] {ST_RUN, ST_HALT_PEND, ST_HALTED} state_e;

  typedef struct packed {
    logic [3:0]         func_code;
    logic               alu_src_b;
    logic [ISA_W-1:0]   imm_ext;
    logic [ISA_RAW-1:0] rs;
    logic [ISA_RAW-1:0] rt;
    logic [ISA_RAW-1:0] dest;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic               jump;
    logic               wwd;
    logic               illegal;
    logic               is_hlt;
  } ctrl_t;

  function automatic logic [ISA_W-1:0] sext8(input logic [7:0] v);
    return {{(ISA_W-8){v[7]}}, v};
  endfunction
endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational TSC instruction decode into the ID/EX control bundle.
// Illegal encodings collapse to a bundle carrying only illegal=1 and FuncCode zero.
module alu_ctrl_decode
  import tsc_isa_pkg::*;
#(
  parameter logic [ISA_RAW-1:0] LINK_REG = ISA_LINK_REG
) (
  input  logic [ISA_W-1:0] instr,
  output ctrl_t            ctrl
);
  logic [3:0]         op;
  logic [5:0]         fn;
  logic [7:0]         imm;
  logic [ISA_RAW-1:0] rd;

  assign op  = instr[15:12];
  assign fn  = instr[5:0];
  assign imm = instr[7:0];
  assign rd  = instr[7:6];

  always_comb begin
    ctrl         = '0;
    ctrl.rs      = instr[11:10];
    ctrl.rt      = instr[9:8];
    ctrl.imm_ext = sext8(imm);
    if (op == OP_RTYPE) begin
      ctrl.dest = rd;
      case (fn)
        FN_ADD: ctrl.func_code = ALU_ADD;
        FN_SUB: ctrl.func_code = ALU_SUB;
        FN_AND: ctrl.func_code = ALU_AND;
        FN_ORR: ctrl.func_code = ALU_OR;
        FN_NOT: ctrl.func_code = ALU_NOT;
        FN_TCP: ctrl.func_code = ALU_NEG;
        FN_SHL: ctrl.func_code = ALU_SHL;
        FN_SHR: ctrl.func_code = ALU_SRA;
        FN_JPR: begin ctrl.func_code = ALU_ZERO; ctrl.jump = 1'b1; end
        FN_JRL: begin
          ctrl.func_code = ALU_ZERO;
          ctrl.jump      = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.dest      = LINK_REG;
        end
        FN_WWD: begin ctrl.func_code = ALU_IDA; ctrl.wwd = 1'b1; end
        FN_HLT: begin ctrl.func_code = ALU_ZERO; ctrl.is_hlt = 1'b1; end
        default: ctrl.illegal = 1'b1;
      endcase
      if (fn <= FN_SHR) ctrl.reg_write = 1'b1;
    end else begin
      ctrl.dest = instr[9:8];
      case (op)
        OP_BNE: begin ctrl.func_code = ALU_NE;  ctrl.branch = 1'b1; end
        OP_BEQ: begin ctrl.func_code = ALU_EQ;  ctrl.branch = 1'b1; end
        OP_BGZ: begin ctrl.func_code = ALU_GTZ; ctrl.branch = 1'b1; end
        OP_BLZ: begin ctrl.func_code = ALU_LTZ; ctrl.branch = 1'b1; end
        OP_ADI: begin ctrl.func_code = ALU_ADD; ctrl.alu_src_b = 1'b1; ctrl.reg_write = 1'b1; end
        OP_ORI: begin
          ctrl.func_code = ALU_OR;
          ctrl.alu_src_b = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.imm_ext   = {{(ISA_W-8){1'b0}}, imm};
        end
        OP_LHI: begin
          ctrl.func_code = ALU_IDB;
          ctrl.alu_src_b = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.imm_ext   = {imm, 8'h00};
        end
        OP_LWD: begin
          ctrl.func_code = ALU_ADD;
          ctrl.alu_src_b = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.mem_read  = 1'b1;
        end
        OP_SWD: begin ctrl.func_code = ALU_ADD; ctrl.alu_src_b = 1'b1; ctrl.mem_write = 1'b1; end
        OP_JMP: begin ctrl.func_code = ALU_ZERO; ctrl.jump = 1'b1; end
        OP_JAL: begin
          ctrl.func_code = ALU_ZERO;
          ctrl.jump      = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.dest      = LINK_REG;
        end
        default: ctrl.illegal = 1'b1;
      endcase
    end
    if (ctrl.illegal) begin
      ctrl           = '0;
      ctrl.illegal   = 1'b1;
      ctrl.func_code = ALU_ZERO;
    end
  end
endmodule

// File: rtl/alu_ctrl_issue.sv
// ID/EX issue stage: decodes TSC instructions into ALU controls and holds them in a
// one-entry registered stage with valid/ready handshakes, flush and a halt FSM.
module alu_ctrl_issue
  import tsc_isa_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int REG_AW   = 2,
  parameter int LINK_REG = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        func_code,
  output logic              alu_src_b,
  output logic [DATA_W-1:0] imm_ext,
  output logic [REG_AW-1:0] rs,
  output logic [REG_AW-1:0] rt,
  output logic [REG_AW-1:0] dest,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              branch,
  output logic              jump,
  output logic              wwd,
  output logic              illegal,
  output logic              halted
);
  ctrl_t  dec_d, ctrl_q;
  state_e state_q;
  logic   out_valid_q, halted_q;
  logic   capture, consume;

  alu_ctrl_decode #(.LINK_REG(ISA_RAW'(LINK_REG))) u_dec (
    .instr (instr),
    .ctrl  (dec_d)
  );

  // Gated by reset so nothing is offered upstream while the stage is being cleared.
  assign in_ready = !reset && (state_q == ST_RUN) && (!out_valid_q || out_ready);
  assign capture  = in_valid && in_ready;
  assign consume  = out_valid_q && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      ctrl_q      <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (flush) begin
            out_valid_q <= 1'b0;
          end else if (capture) begin
            ctrl_q      <= dec_d;
            out_valid_q <= 1'b1;
            if (dec_d.is_hlt) state_q <= ST_HALT_PEND;
          end else if (consume) begin
            out_valid_q <= 1'b0;
          end
        end
        ST_HALT_PEND: begin
          if (flush) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_RUN;
          end else if (consume) begin
            out_valid_q <= 1'b0;
            halted_q    <= 1'b1;
            state_q     <= ST_HALTED;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          halted_q    <= 1'b1;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign halted    = halted_q;
  assign func_code = ctrl_q.func_code;
  assign alu_src_b = ctrl_q.alu_src_b;
  assign imm_ext   = ctrl_q.imm_ext;
  assign rs        = ctrl_q.rs;
  assign rt        = ctrl_q.rt;
  assign dest      = ctrl_q.dest;
  assign reg_write = ctrl_q.reg_write;
  assign mem_read  = ctrl_q.mem_read;
  assign mem_write = ctrl_q.mem_write;
  assign branch    = ctrl_q.branch;
  assign jump      = ctrl_q.jump;
  assign wwd       = ctrl_q.wwd;
  assign illegal   = ctrl_q.illegal;
endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Self-checking bench for alu_ctrl_issue: directed scenarios plus random traffic
// compared each cycle against a table-driven reference of the ISA and handshake rules.
module tb_alu_ctrl_issue;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [15:0] instr = '0;
  logic        in_ready, out_valid, alu_src_b, reg_write, mem_read, mem_write;
  logic        branch, jump, wwd, illegal, halted;
  logic [3:0]  func_code;
  logic [15:0] imm_ext;
  logic [1:0]  rs, rt, dest;

  alu_ctrl_issue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .func_code(func_code),
    .alu_src_b(alu_src_b), .imm_ext(imm_ext), .rs(rs), .rt(rt), .dest(dest),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .jump(jump), .wwd(wwd), .illegal(illegal), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          fc;
    bit          srcb, rw, mr, mw, br, jp, ww, ill, hlt, immv;
    int          dst, rs, rt;
    logic [15:0] imm;
  } exp_t;

  // I-type properties indexed by opcode 0..10
  int r_fc   [0:7]  = '{0, 1, 4, 5, 3, 14, 12, 13};
  int i_fc   [0:10] = '{6, 7, 8, 9, 0, 5, 10, 0, 0, 15, 15};
  int i_immk [0:10] = '{1, 1, 1, 1, 1, 2, 3, 1, 1, 0, 0};  // 1 sext, 2 zext, 3 high byte
  int i_srcb [0:10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0};
  int i_wr   [0:10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 2};  // 1 rt, 2 link

  int   nchk = 0, nfail = 0;
  int   ms = 0;          // 0 run, 1 halt pending, 2 halted
  bit   mvalid = 0;
  exp_t me;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_dec(input logic [15:0] w);
    exp_t e;
    int op, fn, k;
    e = '{default: 0};
    op = int'(w[15:12]);
    fn = int'(w[5:0]);
    e.rs = int'(w[11:10]);
    e.rt = int'(w[9:8]);
    if (op == 15) begin
      if (fn < 8) begin e.fc = r_fc[fn]; e.rw = 1; e.dst = int'(w[7:6]); end
      else if (fn == 25) begin e.fc = 15; e.jp = 1; end
      else if (fn == 26) begin e.fc = 15; e.jp = 1; e.rw = 1; e.dst = 2; end
      else if (fn == 28) begin e.fc = 2; e.ww = 1; end
      else if (fn == 29) begin e.fc = 15; e.hlt = 1; end
      else e.ill = 1;
    end else if (op <= 10) begin
      e.fc   = i_fc[op];
      e.srcb = i_srcb[op] != 0;
      e.br   = op < 4;
      e.mr   = op == 7;
      e.mw   = op == 8;
      e.jp   = op == 9 || op == 10;
      e.rw   = i_wr[op] != 0;
      e.dst  = (i_wr[op] == 2) ? 2 : e.rt;
      k = i_immk[op];
      e.immv = k != 0;
      if (k == 1) e.imm = 16'($signed(w[7:0]));
      else if (k == 2) e.imm = {8'h00, w[7:0]};
      else e.imm = {w[7:0], 8'h00};
    end else e.ill = 1;
    if (e.ill) e.fc = 15;
    return e;
  endfunction

  task automatic check_outs();
    chk("out_valid", out_valid, mvalid);
    chk("halted", halted, ms == 2);
    if (mvalid) begin
      chk("func_code", func_code, me.fc);
      chk("alu_src_b", alu_src_b, me.srcb);
      chk("flags", {reg_write, mem_read, mem_write, branch, jump, wwd, illegal},
          {me.rw, me.mr, me.mw, me.br, me.jp, me.ww, me.ill});
      if (!me.ill) chk("rs_rt", {rs, rt}, {me.rs[1:0], me.rt[1:0]});
      if (me.rw) chk("dest", dest, me.dst);
      if (me.immv) chk("imm_ext", imm_ext, me.imm);
    end
  endtask

  task automatic cyc(input bit iv, input logic [15:0] ins, input bit fl, input bit ordy);
    bit rdy, cap, cons;
    @(negedge clk);
    check_outs();
    in_valid = iv; instr = ins; flush = fl; out_ready = ordy;
    #1;
    rdy = (ms == 0) && (!mvalid || ordy);
    chk("in_ready", in_ready, rdy);
    @(posedge clk);
    cap  = iv && rdy;
    cons = mvalid && ordy;
    if (ms == 1) begin
      if (fl) begin mvalid = 0; ms = 0; end
      else if (cons) begin mvalid = 0; ms = 2; end
    end else if (ms == 0) begin
      if (fl) mvalid = 0;
      else if (cap) begin
        me = ref_dec(ins);
        mvalid = 1;
        if (me.hlt) ms = 1;
      end else if (cons) mvalid = 0;
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] w;
    int fsel;
    int fns [0:11] = '{0, 1, 2, 3, 4, 5, 6, 7, 25, 26, 28, 63};
    w = 16'($urandom);
    if (w[15:12] == 4'hF) begin
      fsel = $urandom_range(0, 11);
      w[5:0] = 6'(fns[fsel]);
    end
    return w;
  endfunction

  initial begin
    // reset state
    #12;
    in_valid = 1; out_ready = 1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_func_code", func_code, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_halted", halted, 0);
    @(negedge clk); reset = 0; in_valid = 0;

    // reset asserted while an entry is held
    cyc(1, 16'h41FF, 0, 0);
    cyc(0, 16'h0, 0, 0);
    @(negedge clk);
    check_outs();
    in_valid = 1; out_ready = 1;
    #2 reset = 1;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_func", func_code, 0);
    chk("rst_mid_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("rst_hold_in_ready", in_ready, 0);
    chk("rst_hold_valid", out_valid, 0);
    @(negedge clk); reset = 0; in_valid = 0;
    ms = 0; mvalid = 0;

    // ADI stream at full rate
    for (int i = 0; i < 5; i++) cyc(1, 16'h41FF, 0, 1);
    cyc(0, 16'h0, 0, 1);

    // LHI then ORI immediate forms
    cyc(1, 16'h605A, 0, 1);
    cyc(1, 16'h5180, 0, 1);
    cyc(0, 16'h0, 0, 1);

    // backpressure: outputs held, nothing lost or duplicated
    cyc(1, 16'h4A12, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 16'hF6C1, 0, 0);
    cyc(1, 16'hF6C1, 0, 1);
    cyc(1, 16'h7B80, 0, 1);
    cyc(0, 16'h0, 0, 1);

    // flush beats a same-cycle BEQ capture
    cyc(1, 16'h1234, 1, 1);
    cyc(0, 16'h0, 0, 1);

    // random traffic (no HLT)
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 9) == 0,
          $urandom_range(0, 3) != 0);
    cyc(0, 16'h0, 0, 1);

    // halt: flush in pending returns to run, second HLT retires
    cyc(1, 16'hF01D, 0, 0);
    cyc(1, 16'h4101, 0, 0);
    cyc(0, 16'h0, 1, 0);
    cyc(1, 16'hF01D, 0, 1);
    cyc(0, 16'h0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 16'h4101, i == 1, 1);
    @(negedge clk);
    check_outs();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
